// File: rtl/m_resample_pkg.sv
// Shared constants and configuration record for the fractional frame resampler.
package m_resample_pkg;

  localparam int CNT_W_DEF  = 16;
  localparam int NUM_CH_MAX = 8;

  // Default-width configuration record: ratio n1 + n3/n2, then decimate by decim.
  typedef struct packed {
    logic [CNT_W_DEF-1:0] n1;
    logic [CNT_W_DEF-1:0] n2;
    logic [CNT_W_DEF-1:0] n3;
    logic [CNT_W_DEF-1:0] decim;
  } cfg_rec_t;

  localparam cfg_rec_t CFG_PASSTHRU = '0;

  function automatic int ch_idx_w(input int num_ch);
    return (num_ch > 1) ? $clog2(num_ch) : 1;
  endfunction

endpackage

// File: rtl/axis_skid_buf.sv
// Two-entry registered skid buffer; s_ready is a flop so no combinational path crosses it.
module axis_skid_buf #(
  parameter int W = 33
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] s_data,
  input  logic         s_valid,
  output logic         s_ready,
  output logic [W-1:0] m_data,
  output logic         m_valid,
  input  logic         m_ready
);

  logic [W-1:0] d0, d1;
  logic [1:0]   cnt, cnt_nxt;
  logic         rdy_q, push, pop;

  // NOTE: combinational blocks assign every output first so no path can infer a latch.
  always_comb begin
    push    = s_valid & rdy_q;
    pop     = (cnt != 2'd0) & m_ready;
    cnt_nxt = cnt + {1'b0, push} - {1'b0, pop};
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop sees pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      // NOTE: both data registers are reset because the head drives o_tdata, which must read 0 in reset.
      d0    <= '0;
      d1    <= '0;
      cnt   <= 2'd0;
      rdy_q <= 1'b0;
    end else begin
      cnt   <= cnt_nxt;
      rdy_q <= (cnt_nxt != 2'd2);
      case ({push, pop})
        2'b10: begin
          if (cnt == 2'd0) d0 <= s_data;
          else             d1 <= s_data;
        end
        2'b01: d0 <= d1;
        2'b11: begin
          if (cnt == 2'd1) d0 <= s_data;
          else begin
            d0 <= d1;
            d1 <= s_data;
          end
        end
        default: ;
      endcase
    end
  end

  assign s_ready = rdy_q;
  assign m_valid = (cnt != 2'd0);
  assign m_data  = d0;

endmodule

// File: rtl/m_resample_frac.sv
// Fractional frame resampler: keeps one frame every n1 + n3/n2 frames, then decimates kept frames.
module m_resample_frac
  import m_resample_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int NUM_CH = 1,
  parameter int CNT_W  = CNT_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [CNT_W-1:0]  cfg_n1,
  input  logic [CNT_W-1:0]  cfg_n2,
  input  logic [CNT_W-1:0]  cfg_n3,
  input  logic [CNT_W-1:0]  cfg_decim,
  input  logic              cfg_load,
  input  logic [DATA_W-1:0] i_tdata,
  input  logic              i_tlast,
  input  logic              i_tvalid,
  output logic              i_tready,
  output logic [DATA_W-1:0] o_tdata,
  output logic              o_tlast,
  output logic              o_tvalid,
  input  logic              o_tready
);

  localparam int CH_W = ch_idx_w(NUM_CH);

  typedef struct packed {
    logic [CNT_W-1:0] n1;
    logic [CNT_W-1:0] n2;
    logic [CNT_W-1:0] n3;
    logic [CNT_W-1:0] decim;
  } cfg_t;

  cfg_t             cfg_act, cfg_pend, cfg_use;
  logic             pend_vld;
  logic [CH_W-1:0]  ch_idx;
  logic [CNT_W-1:0] gcnt, acc, dcnt;
  logic [CNT_W-1:0] gcnt_use, acc_use, dcnt_use;
  logic [CNT_W-1:0] gcnt_nxt, acc_nxt, dcnt_nxt;
  logic [CNT_W:0]   sum;
  logic             fwd_frame, fwd_start, keep, carry, dec_on;
  logic             accept, frame_start, apply, push;
  logic [DATA_W:0]  m_data;

  assign accept      = i_tvalid & i_tready;
  assign frame_start = (ch_idx == '0);
  assign apply       = frame_start & pend_vld;

  // Decision for the frame starting now; a pending config takes effect before it.
  always_comb begin
    cfg_use  = cfg_act;
    gcnt_use = gcnt;
    acc_use  = acc;
    dcnt_use = dcnt;
    if (apply) begin
      cfg_use  = cfg_pend;
      gcnt_use = '0;
      acc_use  = '0;
      dcnt_use = '0;
    end

    sum    = {1'b0, acc_use} + {1'b0, cfg_use.n3};
    carry  = (cfg_use.n2 != '0) && (sum >= {1'b0, cfg_use.n2});
    keep   = (cfg_use.n1 == '0) || (gcnt_use == '0);
    dec_on = (cfg_use.decim > CNT_W'(1));

    gcnt_nxt = gcnt_use;
    acc_nxt  = acc_use;
    if (cfg_use.n1 == '0) begin
      gcnt_nxt = '0;
    end else if (gcnt_use == '0) begin
      gcnt_nxt = cfg_use.n1 - CNT_W'(1) + CNT_W'(carry);
      acc_nxt  = carry ? CNT_W'(sum - {1'b0, cfg_use.n2}) : CNT_W'(sum);
    end else begin
      gcnt_nxt = gcnt_use - CNT_W'(1);
    end

    dcnt_nxt = dcnt_use;
    if (!dec_on)   dcnt_nxt = '0;
    else if (keep) dcnt_nxt = (dcnt_use == cfg_use.decim - CNT_W'(1)) ? '0 : dcnt_use + CNT_W'(1);

    fwd_start = keep && (!dec_on || (dcnt_use == '0));
    push      = accept && ((frame_start ? fwd_start : fwd_frame) || i_tlast);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cfg_act   <= '0;
      cfg_pend  <= '0;
      pend_vld  <= 1'b0;
      ch_idx    <= '0;
      gcnt      <= '0;
      acc       <= '0;
      dcnt      <= '0;
      fwd_frame <= 1'b0;
    end else begin
      if (accept) begin
        if (apply) begin
          cfg_act  <= cfg_pend;
          pend_vld <= 1'b0;
        end
        if (i_tlast) begin
          ch_idx    <= '0;
          gcnt      <= '0;
          acc       <= '0;
          dcnt      <= '0;
          fwd_frame <= 1'b0;
        end else begin
          ch_idx <= (ch_idx == CH_W'(NUM_CH - 1)) ? '0 : ch_idx + CH_W'(1);
          if (frame_start) begin
            gcnt      <= gcnt_nxt;
            acc       <= acc_nxt;
            dcnt      <= dcnt_nxt;
            fwd_frame <= fwd_start;
          end
        end
      end
      // A load in the same cycle as an apply is kept for the next boundary.
      if (cfg_load) begin
        cfg_pend <= '{n1: cfg_n1, n2: cfg_n2, n3: cfg_n3, decim: cfg_decim};
        pend_vld <= 1'b1;
      end
    end
  end

  axis_skid_buf #(.W(DATA_W + 1)) u_skid (
    .clk     (clk),
    .rst_n   (rst_n),
    .s_data  ({i_tlast, i_tdata}),
    .s_valid (push),
    .s_ready (i_tready),
    .m_data  (m_data),
    .m_valid (o_tvalid),
    .m_ready (o_tready)
  );

  assign {o_tlast, o_tdata} = m_data;

endmodule

// File: tb/tb_m_resample_frac.sv
// Scoreboard bench: stimulus pushes hand-derived expected beats, monitors pop and compare.
module tb_m_resample_frac;
  import m_resample_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  cfg_rec_t    cfg = CFG_PASSTHRU;
  logic        cfg_load = 1'b0;

  logic [31:0] i_tdata = '0, o_tdata;
  logic        i_tlast = 1'b0, i_tvalid = 1'b0, i_tready;
  logic        o_tlast, o_tvalid, o_tready = 1'b1;

  logic [31:0] i_tdata_b = '0, o_tdata_b;
  logic        i_tlast_b = 1'b0, i_tvalid_b = 1'b0, i_tready_b;
  logic        o_tlast_b, o_tvalid_b, o_tready_b = 1'b1;

  logic [32:0] exp_q[$];
  logic [32:0] exp_b_q[$];
  int          n_cmp = 0, n_err = 0;
  int          cyc = 0, acc_edge = 0, t2_acc = 0;
  int          mon_first = -1, mon_last = 0;
  int          rdy_mode = 0;
  logic        hold_v = 1'b0;
  logic [32:0] hold_d = '0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  m_resample_frac #(.DATA_W(32), .NUM_CH(1), .CNT_W(16)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .cfg_n1(cfg.n1), .cfg_n2(cfg.n2), .cfg_n3(cfg.n3), .cfg_decim(cfg.decim), .cfg_load(cfg_load),
    .i_tdata(i_tdata), .i_tlast(i_tlast), .i_tvalid(i_tvalid), .i_tready(i_tready),
    .o_tdata(o_tdata), .o_tlast(o_tlast), .o_tvalid(o_tvalid), .o_tready(o_tready)
  );

  m_resample_frac #(.DATA_W(32), .NUM_CH(2), .CNT_W(16)) u_dut_b (
    .clk(clk), .rst_n(rst_n),
    .cfg_n1(cfg.n1), .cfg_n2(cfg.n2), .cfg_n3(cfg.n3), .cfg_decim(cfg.decim), .cfg_load(cfg_load),
    .i_tdata(i_tdata_b), .i_tlast(i_tlast_b), .i_tvalid(i_tvalid_b), .i_tready(i_tready_b),
    .o_tdata(o_tdata_b), .o_tlast(o_tlast_b), .o_tvalid(o_tvalid_b), .o_tready(o_tready_b)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Output ready pattern, updated just after each rising edge.
  always @(posedge clk) begin
    #1;
    case (rdy_mode)
      0:       o_tready = 1'b1;
      1:       o_tready = 1'($urandom_range(0, 1));
      default: o_tready = 1'b0;
    endcase
  end

  always @(negedge clk) begin
    if (!rst_n) begin
      hold_v = 1'b0;
    end else begin
      if (hold_v) begin
        check("hold_valid", 64'(o_tvalid), 64'd1);
        check("hold_data", 64'({o_tlast, o_tdata}), 64'(hold_d));
      end
      if (o_tvalid && o_tready) begin
        if (exp_q.size() == 0) check("out_unexpected_qsize", 64'(exp_q.size()), 64'd1);
        else begin
          check("out_beat", 64'({o_tlast, o_tdata}), 64'(exp_q.pop_front()));
          if (mon_first < 0) mon_first = cyc + 1;
          mon_last = cyc + 1;
        end
      end
      hold_v = o_tvalid && !o_tready;
      hold_d = {o_tlast, o_tdata};
    end
  end

  always @(negedge clk) begin
    if (rst_n && o_tvalid_b && o_tready_b) begin
      if (exp_b_q.size() == 0) check("outb_unexpected_qsize", 64'(exp_b_q.size()), 64'd1);
      else check("outb_beat", 64'({o_tlast_b, o_tdata_b}), 64'(exp_b_q.pop_front()));
    end
  end

  task automatic load_cfg(input cfg_rec_t c);
    cfg = c;
    cfg_load = 1'b1;
    @(posedge clk); #1;
    cfg_load = 1'b0;
  endtask

  task automatic send(input logic [31:0] d, input logic l);
    int n = 0;
    logic rdy;
    i_tvalid = 1'b1; i_tdata = d; i_tlast = l;
    do begin rdy = i_tready; @(posedge clk); #1; n++; end while (!rdy && n < 200);
    if (!rdy) check("send_timeout", 64'(rdy), 64'd1);
    acc_edge = cyc;
    i_tvalid = 1'b0; i_tlast = 1'b0;
  endtask

  task automatic send_b(input logic [31:0] d);
    int n = 0;
    logic rdy;
    i_tvalid_b = 1'b1; i_tdata_b = d;
    do begin rdy = i_tready_b; @(posedge clk); #1; n++; end while (!rdy && n < 200);
    if (!rdy) check("sendb_timeout", 64'(rdy), 64'd1);
    i_tvalid_b = 1'b0;
  endtask

  task automatic push_exp(input logic [31:0] d, input logic l);
    exp_q.push_back({l, d});
  endtask

  task automatic wait_drain();
    int n = 0;
    while ((exp_q.size() != 0 || exp_b_q.size() != 0) && n < 3000) begin
      @(posedge clk); n++;
    end
    #1;
    check("drain_a", 64'(exp_q.size()), 64'd0);
    check("drain_b", 64'(exp_b_q.size()), 64'd0);
    repeat (4) @(posedge clk);
    #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] d;
    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_o_tvalid", 64'(o_tvalid), 64'd0);
    check("rst_i_tready", 64'(i_tready), 64'd0);
    check("rst_o_tdata", 64'(o_tdata), 64'd0);
    check("rst_o_tlast", 64'(o_tlast), 64'd0);
    check("rst_b_i_tready", 64'(i_tready_b), 64'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("post_rst_i_tready", 64'(i_tready), 64'd1);

    // Pass-through: 100 beats back to back, 1-cycle latency, no bubbles
    load_cfg('{n1: 16'd0, n2: 16'd0, n3: 16'd0, decim: 16'd0});
    mon_first = -1;
    for (int i = 0; i < 100; i++) begin
      d = 32'h0200_0000 + 32'(i);
      push_exp(d, 1'b0);
      send(d, 1'b0);
      if (i == 0) t2_acc = acc_edge;
    end
    wait_drain();
    check("pass_latency", 64'(mon_first - t2_acc), 64'd1);
    check("pass_no_bubble", 64'(mon_last - mon_first), 64'd99);

    // Ratio 2 + 1/4: kept offsets 0,2,4,6 of every 9
    load_cfg('{n1: 16'd2, n2: 16'd4, n3: 16'd1, decim: 16'd0});
    for (int i = 0; i < 900; i++) begin
      d = 32'h0300_0000 + 32'(i);
      if ((i % 9) inside {0, 2, 4, 6}) push_exp(d, 1'b0);
      send(d, 1'b0);
    end
    wait_drain();

    // Ratio 2 then decimate by 3: every 6th beat
    load_cfg('{n1: 16'd2, n2: 16'd0, n3: 16'd0, decim: 16'd3});
    for (int i = 0; i < 24; i++) begin
      d = 32'h0400_0000 + 32'(i);
      if (i % 6 == 0) push_exp(d, 1'b0);
      send(d, 1'b0);
    end
    wait_drain();

    // tlast on beat 4 is always forwarded and restarts the cadence
    load_cfg('{n1: 16'd3, n2: 16'd0, n3: 16'd0, decim: 16'd0});
    for (int i = 0; i < 10; i++) begin
      d = 32'h0500_0000 + 32'(i);
      if (i == 0 || i == 3 || i == 5 || i == 8) push_exp(d, 1'b0);
      if (i == 4) push_exp(d, 1'b1);
      send(d, i == 4);
    end
    wait_drain();

    // Back-to-back loads: last one wins; n2=0 disables the fraction
    load_cfg('{n1: 16'd5, n2: 16'd0, n3: 16'd0, decim: 16'd0});
    load_cfg('{n1: 16'd2, n2: 16'd0, n3: 16'd5, decim: 16'd0});
    for (int i = 0; i < 8; i++) begin
      d = 32'h0580_0000 + 32'(i);
      if (i % 2 == 0) push_exp(d, 1'b0);
      send(d, 1'b0);
    end
    wait_drain();

    // Two channels, ratio 3: frames 0 and 3 kept
    load_cfg('{n1: 16'd3, n2: 16'd0, n3: 16'd0, decim: 16'd0});
    for (int i = 0; i < 12; i++) begin
      d = 32'h0600_0000 + 32'(i);
      if (i inside {0, 1, 6, 7}) exp_b_q.push_back({1'b0, d});
      send_b(d);
    end
    wait_drain();

    // Random backpressure, ratio 2 + 1/3, then reset with beats buffered
    load_cfg('{n1: 16'd2, n2: 16'd3, n3: 16'd1, decim: 16'd0});
    rdy_mode = 1;
    for (int i = 0; i < 30; i++) begin
      d = 32'h0700_0000 + 32'(i);
      if ((i % 7) inside {0, 2, 4}) push_exp(d, 1'b0);
      send(d, 1'b0);
    end
    rdy_mode = 2;
    repeat (4) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    check("midrst_o_tvalid", 64'(o_tvalid), 64'd0);
    check("midrst_i_tready", 64'(i_tready), 64'd0);
    check("midrst_o_tdata", 64'(o_tdata), 64'd0);
    exp_q.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("after_rst_i_tready", 64'(i_tready), 64'd1);
    check("after_rst_o_tvalid", 64'(o_tvalid), 64'd0);

    // Config returned to pass-through by reset
    rdy_mode = 1;
    for (int i = 0; i < 20; i++) begin
      d = 32'h0800_0000 + 32'(i);
      push_exp(d, 1'b0);
      send(d, 1'b0);
    end
    wait_drain();
    rdy_mode = 0;
    repeat (2) @(posedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
